// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, format class enum, decoded bundle.
// Used by instr_decode_stage and imm_gen.
// No ports. Not tied to XLEN or PC_W, so the immediate and PC live outside the bundle.
package decode_pkg;

  // RV32/RV64 base opcodes. The low two bits are always 2'b11 for the 32-bit encoding.
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Format class. Values are visible on the fmt port, so the encoding is fixed.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_t;

  // Width-independent part of the decoded bundle.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_t       fmt;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    opcode:  7'd0,
    rd:      5'd0,
    funct3:  3'd0,
    rs1:     5'd0,
    rs2:     5'd0,
    funct7:  7'd0,
    fmt:     FMT_NONE,
    illegal: 1'b0
  };

  // Split the fixed-position register and function fields out of an instruction word.
  function automatic dec_t split_fields(input logic [31:0] w, input fmt_t f, input logic ill);
    dec_t d;
    d.opcode  = w[6:0];
    d.rd      = w[11:7];
    d.funct3  = w[14:12];
    d.rs1     = w[19:15];
    d.rs2     = w[24:20];
    d.funct7  = w[31:25];
    d.fmt     = f;
    d.illegal = ill;
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Format classification and immediate generation for one instruction word.
// Purely combinational (zero latency); no handshake, no backpressure.
// Ports: instr (raw word) -> fmt (format class), imm (sign-extended, XLEN bits), illegal.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output fmt_t            fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  fmt_t        fmt_c;
  logic [31:0] imm32;

  // Compressed encodings (instr[1:0] != 2'b11) are never valid here.
  always_comb begin
    fmt_c = FMT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_REG:                                         fmt_c = FMT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE:  fmt_c = FMT_I;
        OP_STORE:                                       fmt_c = FMT_S;
        OP_BRANCH:                                      fmt_c = FMT_B;
        OP_LUI, OP_AUIPC:                               fmt_c = FMT_U;
        OP_JAL:                                         fmt_c = FMT_J;
        default:                                        fmt_c = FMT_NONE;
      endcase
    end
  end

  // Standard RISC-V bit scatter, built at 32 bits; instr[31] is the sign in every format.
  always_comb begin
    imm32 = 32'd0;
    case (fmt_c)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'd0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign fmt     = fmt_c;
  assign illegal = (fmt_c == FMT_NONE);
  // Sign-extending size cast: the 32-bit value is already sign-correct, widen for RV64.
  assign imm     = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage: splits fields, classifies format, builds immediate.
// Latency 1 cycle (accept in N, visible in N+1); full throughput through a 2-entry skid buffer.
// Backpressure: in_ready = !skid_valid is registered, so no combinational path from out_ready.
//
// Ports: clk/reset (sync, active-high), flush (sync kill of both entries),
//   in_valid/in_ready/in_instr/in_pc upstream handshake,
//   out_valid/out_ready plus out_pc, opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal.
// Optional macro DECODE_STATS_EN adds stat_decoded / stat_illegal 32-bit transfer counters.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
`ifdef DECODE_STATS_EN
  output logic [31:0]     stat_decoded,
  output logic [31:0]     stat_illegal,
`endif
  output logic            illegal
);

  // Decode of the incoming word, done before either register.
  fmt_t            in_fmt;
  logic [XLEN-1:0] in_imm;
  logic            in_illegal;
  dec_t            in_dec;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .fmt     (in_fmt),
    .imm     (in_imm),
    .illegal (in_illegal)
  );

  assign in_dec = split_fields(in_instr, in_fmt, in_illegal);

  // Output register (entry presented downstream) and skid register (overflow entry).
  logic            out_vld_q, out_vld_d;
  dec_t            out_dec_q, out_dec_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [PC_W-1:0] out_pc_q,  out_pc_d;

  logic            skid_vld_q, skid_vld_d;
  dec_t            skid_dec_q, skid_dec_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic [PC_W-1:0] skid_pc_q,  skid_pc_d;

  logic in_fire;
  logic out_fire;

  // reset gates in_ready directly so the stage refuses input during reset
  // and is ready on the very first cycle after it.
  assign in_ready = !skid_vld_q && !reset;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_vld_q && out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dec_d  = out_dec_q;
    out_imm_d  = out_imm_q;
    out_pc_d   = out_pc_q;
    skid_vld_d = skid_vld_q;
    skid_dec_d = skid_dec_q;
    skid_imm_d = skid_imm_q;
    skid_pc_d  = skid_pc_q;

    if (flush) begin
      // Kill both entries and drop whatever is on the input this cycle.
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_fire) begin
      // Output slot is free this cycle. The skid entry is older than any new
      // input, and in_ready is low whenever it is full, so the two never compete.
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dec_d  = skid_dec_q;
        out_imm_d  = skid_imm_q;
        out_pc_d   = skid_pc_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_vld_d  = 1'b1;
        out_dec_d  = in_dec;
        out_imm_d  = in_imm;
        out_pc_d   = in_pc;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (in_fire) begin
      // Output is stalled: park the accepted bundle in the skid slot.
      skid_vld_d = 1'b1;
      skid_dec_d = in_dec;
      skid_imm_d = in_imm;
      skid_pc_d  = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_dec_q  <= DEC_RESET;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      skid_vld_q <= 1'b0;
      skid_dec_q <= DEC_RESET;
      skid_imm_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dec_q  <= out_dec_d;
      out_imm_q  <= out_imm_d;
      out_pc_q   <= out_pc_d;
      skid_vld_q <= skid_vld_d;
      skid_dec_q <= skid_dec_d;
      skid_imm_q <= skid_imm_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_pc    = out_pc_q;
  assign opcode    = out_dec_q.opcode;
  assign rd        = out_dec_q.rd;
  assign funct3    = out_dec_q.funct3;
  assign rs1       = out_dec_q.rs1;
  assign rs2       = out_dec_q.rs2;
  assign funct7    = out_dec_q.funct7;
  assign fmt       = out_dec_q.fmt;
  assign imm       = out_imm_q;
  assign illegal   = out_dec_q.illegal;

`ifdef DECODE_STATS_EN
  // Transfer counters: count what downstream actually took, wrap naturally,
  // and deliberately ignore flush.
  logic [31:0] stat_dec_q, stat_dec_d;
  logic [31:0] stat_ill_q, stat_ill_d;

  always_comb begin
    stat_dec_d = stat_dec_q;
    stat_ill_d = stat_ill_q;
    if (out_fire) begin
      stat_dec_d = stat_dec_q + 32'd1;
      if (out_dec_q.illegal) begin
        stat_ill_d = stat_ill_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dec_q <= 32'd0;
      stat_ill_q <= 32'd0;
    end else begin
      stat_dec_q <= stat_dec_d;
      stat_ill_q <= stat_ill_d;
    end
  end

  assign stat_decoded = stat_dec_q;
  assign stat_illegal = stat_ill_q;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed vectors, a queue-based behavioural model
// checked every cycle, and hand-computed literal expectations.
// One XLEN=32 instance carries the main stream; an XLEN=64 instance checks widening.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // XLEN=32 instance signals
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;

  // XLEN=64 instance signals
  logic        flush64, in_valid64, out_ready64;
  logic [31:0] in_instr64, in_pc64;
  logic        in_ready64, out_valid64, illegal64;
  logic [31:0] out_pc64;
  logic [63:0] imm64;
  logic [6:0]  opcode64, funct7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt64;

`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded, stat_illegal, stat_decoded64, stat_illegal64;
`endif

  instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .fmt(fmt), .imm(imm),
`ifdef DECODE_STATS_EN
    .stat_decoded(stat_decoded), .stat_illegal(stat_illegal),
`endif
    .illegal(illegal)
  );

  instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_pc(out_pc64),
    .opcode(opcode64), .rd(rd64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
    .funct7(funct7_64), .fmt(fmt64), .imm(imm64),
`ifdef DECODE_STATS_EN
    .stat_decoded(stat_decoded64), .stat_illegal(stat_illegal64),
`endif
    .illegal(illegal64)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        illegal;
  } exp_t;

  // Immediate built arithmetically: shifted sign-extended word plus scattered fields.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic signed [63:0] s;
    logic [63:0] t;
    s = $signed({{32{w[31]}}, w});
    e.pc = pc;
    e.opcode = w[6:0];
    e.rd = w[11:7];
    e.funct3 = w[14:12];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.funct7 = w[31:25];
    case (w[6:0])
      7'h33:                             e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd1;
      7'h23:                             e.fmt = 3'd2;
      7'h63:                             e.fmt = 3'd3;
      7'h37, 7'h17:                      e.fmt = 3'd4;
      7'h6F:                             e.fmt = 3'd5;
      default:                           e.fmt = 3'd7;
    endcase
    if (w[1:0] != 2'b11) e.fmt = 3'd7;
    e.illegal = (e.fmt == 3'd7);
    case (e.fmt)
      3'd1: e.imm = s >>> 20;
      3'd2: begin t = s >>> 25; e.imm = (t << 5) + 64'(w[11:7]); end
      3'd3: begin
        t = s >>> 31;
        e.imm = (t << 12) + (64'(w[7]) << 11) + (64'(w[30:25]) << 5) + (64'(w[11:8]) << 1);
      end
      3'd4: begin t = s >>> 12; e.imm = t << 12; end
      3'd5: begin
        t = s >>> 31;
        e.imm = (t << 20) + (64'(w[19:12]) << 12) + (64'(w[20]) << 11) + (64'(w[30:21]) << 1);
      end
      default: e.imm = 64'd0;
    endcase
    return e;
  endfunction

  function automatic logic [127:0] exp_pack(input exp_t e);
    return {28'd0, e.pc, e.opcode, e.rd, e.funct3, e.rs1, e.rs2, e.funct7, e.fmt, e.illegal, e.imm[31:0]};
  endfunction

  exp_t        q[$];
  logic [31:0] emitted[$];
  int          xfer_cnt = 0;
  logic        mon_en = 1'b0;

  // Compare process: pre-edge state checked at negedge, then model advanced for the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(!reset && q.size() < 2));
      if (out_valid && q.size() != 0)
        chk("bundle", {28'd0, out_pc, opcode, rd, funct3, rs1, rs2, funct7, fmt, illegal, imm},
            exp_pack(q[0]));
      if (out_valid && out_ready && !reset) begin
        if (q.size() != 0) void'(q.pop_front());
        emitted.push_back(out_pc);
        xfer_cnt++;
      end
      if (reset) begin
        q.delete();
        xfer_cnt = 0;
      end else if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        q.push_back(model(in_instr, in_pc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until accepted; bounded wait.
  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    logic rdy;
    int   n;
    logic done;
    n = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = w;
    in_pc = pc;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready;
      step();
      if (rdy) done = 1'b1;
      else begin
        n++;
        if (n > 40) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL send_timeout: pc %0h not accepted after %0d cycles", pc, n);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int n_emit;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; in_instr64 = 32'd0; in_pc64 = 32'd0; out_ready64 = 1'b1;
    step();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_fmt", 128'(fmt), 128'd7);
    chk("rst_imm", 128'(imm), 128'd0);
    chk("rst_opcode", 128'(opcode), 128'd0);
    chk("rst_pc", 128'(out_pc), 128'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", 128'(in_ready), 128'd1);
    step();

    // Reset mid-stream with both entries full: nothing may emerge afterwards.
    out_ready = 1'b0;
    send(32'h00100093, 32'h10);
    send(32'h00200113, 32'h14);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    n_emit = emitted.size();
    repeat (3) step();
    chk("midrst_no_emit", 128'(emitted.size()), 128'(n_emit));

    // addi x1,x2,-1
    send(32'hFFF10093, 32'h100);
    @(negedge clk);
    chk("addi_valid", 128'(out_valid), 128'd1);
    chk("addi_opcode", 128'(opcode), 128'h13);
    chk("addi_rd", 128'(rd), 128'd1);
    chk("addi_rs1", 128'(rs1), 128'd2);
    chk("addi_fmt", 128'(fmt), 128'd1);
    chk("addi_imm", 128'(imm), 128'hFFFFFFFF);
    chk("addi_illegal", 128'(illegal), 128'd0);
    chk("addi_pc", 128'(out_pc), 128'h100);
    step();

    // sw x5,8(x2) then beq x0,x0,-4 back to back
    in_valid = 1'b1; in_instr = 32'h00512423; in_pc = 32'h104;
    step();
    in_instr = 32'hFE000EE3; in_pc = 32'h108;
    @(negedge clk);
    chk("sw_fmt", 128'(fmt), 128'd2);
    chk("sw_imm", 128'(imm), 128'd8);
    chk("sw_rs2", 128'(rs2), 128'd5);
    chk("sw_pc", 128'(out_pc), 128'h104);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("beq_valid", 128'(out_valid), 128'd1);
    chk("beq_fmt", 128'(fmt), 128'd3);
    chk("beq_imm", 128'(imm), 128'hFFFFFFFC);
    chk("beq_pc", 128'(out_pc), 128'h108);
    step();

    // XLEN=64: lui x3,0x12345 and addi x1,x2,-1
    in_valid64 = 1'b1; in_instr64 = 32'h123451B7; in_pc64 = 32'h200;
    step();
    in_valid64 = 1'b0;
    @(negedge clk);
    chk("lui64_valid", 128'(out_valid64), 128'd1);
    chk("lui64_fmt", 128'(fmt64), 128'd4);
    chk("lui64_imm", 128'(imm64), 128'h0000000012345000);
    chk("lui64_rd", 128'(rd64), 128'd3);
    step();
    in_valid64 = 1'b1; in_instr64 = 32'hFFF10093; in_pc64 = 32'h204;
    step();
    in_valid64 = 1'b0;
    @(negedge clk);
    chk("addi64_imm", 128'(imm64), 128'hFFFFFFFFFFFFFFFF);
    chk("addi64_fmt", 128'(fmt64), 128'd1);
    step();

    // Backpressure: 4 instructions, out_ready low for 3 cycles.
    emitted.delete();
    fork
      begin
        send(32'h00100093, 32'h500);
        send(32'h00208113, 32'h504);
        @(negedge clk);
        chk("bp_rdy_drop", 128'(in_ready), 128'd0);
        step();
        send(32'h002081B3, 32'h508);
        send(32'h00312023, 32'h50C);
      end
      begin
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    chk("bp_count", 128'(emitted.size()), 128'd4);
    if (emitted.size() == 4) begin
      chk("bp_order0", 128'(emitted[0]), 128'h500);
      chk("bp_order1", 128'(emitted[1]), 128'h504);
      chk("bp_order2", 128'(emitted[2]), 128'h508);
      chk("bp_order3", 128'(emitted[3]), 128'h50C);
    end

    // Flush with one entry held and a new input presented (input must be dropped).
    out_ready = 1'b0;
    send(32'h00400213, 32'h300);
    in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h304; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush1_out_valid", 128'(out_valid), 128'd0);
    chk("flush1_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    n_emit = emitted.size();
    repeat (3) step();
    chk("flush1_no_emit", 128'(emitted.size()), 128'(n_emit));

    // Flush with both entries full and in_valid high.
    out_ready = 1'b0;
    send(32'h00600313, 32'h310);
    send(32'h00700393, 32'h314);
    in_valid = 1'b1; in_instr = 32'h00800413; in_pc = 32'h318; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", 128'(out_valid), 128'd0);
    chk("flush2_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    n_emit = emitted.size();
    repeat (3) step();
    chk("flush2_no_emit", 128'(emitted.size()), 128'(n_emit));

    // Illegal encodings.
    send(32'h00000000, 32'h400);
    @(negedge clk);
    chk("ill0_illegal", 128'(illegal), 128'd1);
    chk("ill0_fmt", 128'(fmt), 128'd7);
    chk("ill0_imm", 128'(imm), 128'd0);
    step();
    send(32'h0000007F, 32'h404);
    @(negedge clk);
    chk("ill7f_illegal", 128'(illegal), 128'd1);
    chk("ill7f_fmt", 128'(fmt), 128'd7);
    chk("ill7f_imm", 128'(imm), 128'd0);
    chk("ill7f_opcode", 128'(opcode), 128'h7F);
    step();

    repeat (4) step();
    chk("drained", 128'(q.size()), 128'd0);
    chk("total_xfers", 128'(xfer_cnt), 128'd9);

`ifdef DECODE_STATS_EN
    chk("stat_decoded", 128'(stat_decoded), 128'(xfer_cnt));
    chk("stat_illegal", 128'(stat_illegal), 128'd2);
    chk("stat_decoded64", 128'(stat_decoded64), 128'd2);
    chk("stat_illegal64", 128'(stat_illegal64), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
